pu_sched: RTL

Job sequencer for one processing unit (MAC cluster plus weight and result memories). It accepts a layer job: N output neurons, each the sum of C input chunks. For every beat it handshakes input chunks from the upstream input buffer, walks the weight-memory read address, and generates the MAC control flags: enable, done, bias, relu, bias select and cache clear. It also schedules result-memory writes once the MAC pipeline latency has elapsed. It sits between the top-level layer controller and the PU.

---
 rtl/pu_pkg.sv | 29 ++
 rtl/pu_wr_delay.sv | 41 ++++
 rtl/pu_sched.sv | 134 +++++++++++++
 3 files changed

// File: rtl/pu_pkg.sv
// Shared types and constants for the processing-unit job sequencer.
package pu_pkg;

  localparam int unsigned WADDR_WIDTH = 7;
  localparam int unsigned RADDR_WIDTH = 6;
  localparam int unsigned BIAS_LANES  = 8;
  localparam int unsigned BIAS_AW     = $clog2(BIAS_LANES);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_FIN
  } pu_state_e;

  // Job configuration captured at start; the weight base goes straight into the pointer.
  typedef struct packed {
    logic [RADDR_WIDTH:0] num_out;
    logic [WADDR_WIDTH:0] num_chunks;
    logic                 bias;
    logic                 relu;
  } pu_cfg_t;

  function automatic logic cfg_empty(input logic [RADDR_WIDTH:0] n,
                                     input logic [WADDR_WIDTH:0] c);
    return (n == '0) || (c == '0);
  endfunction

endpackage

// File: rtl/pu_wr_delay.sv
// Fixed-latency valid+address delay line aligning result writes with the MAC output.
module pu_wr_delay #(
  parameter int unsigned LAT = 2,
  parameter int unsigned AW  = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load_valid,
  input  logic [AW-1:0] load_addr,
  output logic          wr_valid,
  output logic [AW-1:0] wr_addr,
  output logic          pending_c
);

  logic [LAT-1:0] vld_q;
  logic [AW-1:0]  addr_q [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(LAT); i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= load_valid;
      addr_q[0] <= load_addr;
      for (int i = 1; i < int'(LAT); i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign wr_valid = vld_q[LAT-1];
  assign wr_addr  = addr_q[LAT-1];

  // Set while some entry will still be in flight after the next cycle.
  always_comb begin
    pending_c = (LAT > 1) && load_valid;
    for (int i = 0; i < int'(LAT) - 2; i++) pending_c = pending_c | vld_q[i];
  end

endmodule

// File: rtl/pu_sched.sv
// Layer-job sequencer: chunk handshake, weight address walk, MAC flags and result writes.
module pu_sched
  import pu_pkg::*;
#(
  parameter int unsigned MAC_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_start,
  input  logic [RADDR_WIDTH:0]   in_cfg_num_out,
  input  logic [WADDR_WIDTH:0]   in_cfg_num_chunks,
  input  logic [WADDR_WIDTH-1:0] in_cfg_w_base,
  input  logic                   in_cfg_bias,
  input  logic                   in_cfg_relu,
  input  logic                   in_data_valid,
  output logic                   out_data_ready,
  output logic                   out_busy,
  output logic                   out_job_done,
  output logic                   out_mac_en,
  output logic                   out_done,
  output logic                   out_add_bias,
  output logic                   out_relu,
  output logic                   out_cache_clear,
  output logic [BIAS_AW-1:0]     out_bias_addr,
  output logic [WADDR_WIDTH-1:0] out_w_rd_addr,
  output logic                   out_r_wr_en,
  output logic [RADDR_WIDTH-1:0] out_r_wr_addr
);

  localparam int unsigned OW = RADDR_WIDTH + 1;
  localparam int unsigned CW = WADDR_WIDTH + 1;

  pu_state_e              state_q, state_d;
  pu_cfg_t                cfg_q;
  logic [OW-1:0]          out_idx_q;
  logic [CW-1:0]          chunk_idx_q;
  logic [WADDR_WIDTH-1:0] w_ptr_q;
  logic [RADDR_WIDTH-1:0] done_idx_q;
  logic                   fire, last_chunk, last_out, drain_pending;
  logic                   launch;

  assign fire       = out_data_ready & in_data_valid;
  assign last_chunk = chunk_idx_q == (cfg_q.num_chunks - CW'(1));
  assign last_out   = out_idx_q == (cfg_q.num_out - OW'(1));
  assign launch     = (state_q == ST_IDLE) && in_start;

  // The pointer register is the read address, so it is valid throughout the fire cycle.
  assign out_w_rd_addr = w_ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (in_start) begin
                  state_d = cfg_empty(in_cfg_num_out, in_cfg_num_chunks) ? ST_FIN : ST_RUN;
                end
      ST_RUN:   if (fire && last_chunk && last_out) state_d = ST_DRAIN;
      ST_DRAIN: if (!drain_pending) state_d = ST_FIN;
      ST_FIN:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Registered handshake, status and MAC control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_ready  <= 1'b0;
      out_busy        <= 1'b0;
      out_job_done    <= 1'b0;
      out_cache_clear <= 1'b0;
      out_mac_en      <= 1'b0;
      out_done        <= 1'b0;
      out_add_bias    <= 1'b0;
      out_relu        <= 1'b0;
      out_bias_addr   <= '0;
      done_idx_q      <= '0;
    end else begin
      out_data_ready  <= state_d == ST_RUN;
      out_busy        <= state_d != ST_IDLE;
      out_job_done    <= state_q == ST_FIN;
      out_cache_clear <= launch && (state_d == ST_RUN);
      out_mac_en      <= fire;
      out_done        <= fire & last_chunk;
      out_add_bias    <= fire & last_chunk & cfg_q.bias;
      out_relu        <= fire & last_chunk & cfg_q.relu;
      out_bias_addr   <= fire ? out_idx_q[BIAS_AW-1:0] : '0;
      done_idx_q      <= out_idx_q[RADDR_WIDTH-1:0];
    end
  end

  // Job counters: loaded at launch, advanced only on a fired beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q       <= '0;
      out_idx_q   <= '0;
      chunk_idx_q <= '0;
      w_ptr_q     <= '0;
    end else if (launch) begin
      cfg_q       <= '{num_out:    in_cfg_num_out,
                       num_chunks: in_cfg_num_chunks,
                       bias:       in_cfg_bias,
                       relu:       in_cfg_relu};
      out_idx_q   <= '0;
      chunk_idx_q <= '0;
      w_ptr_q     <= in_cfg_w_base;
    end else if (fire) begin
      w_ptr_q <= w_ptr_q + WADDR_WIDTH'(1);
      if (last_chunk) begin
        chunk_idx_q <= '0;
        out_idx_q   <= out_idx_q + OW'(1);
      end else begin
        chunk_idx_q <= chunk_idx_q + CW'(1);
      end
    end
  end

  pu_wr_delay #(
    .LAT (MAC_LAT),
    .AW  (RADDR_WIDTH)
  ) u_wr_delay (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (out_done),
    .load_addr  (done_idx_q),
    .wr_valid   (out_r_wr_en),
    .wr_addr    (out_r_wr_addr),
    .pending_c  (drain_pending)
  );

endmodule
